move_collision_responder: RTL and testbench

MOVE_COLLISION_RESPONDER -- requirements
Module: move_collision_responder

---
 rtl/move_collision_responder.sv | 211 +++++++++++++++++++++
 tb/tb_move_collision_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_collision_responder.sv
// move_collision_responder
//
// Decides whether a character may move to a proposed top-left position.
// A request first gets a screen-bounds check. If that passes, the block
// scans the obstacle rectangle table and then the three peer characters,
// one check per clock, and stops at the first overlap found.
//
// Ports
//   debouncingclock        sole clock, all state changes on the rising edge
//   reset                  synchronous, active-high
//   test_active            request; held high by the mover until result_valid
//   test_x, test_y         proposed top-left position (latched on accept)
//   peerN_x, peerN_y       top-left of the other characters (sampled live)
//   peer_en                bit i enables peer i in the scan
//   obs_wr_*               obstacle table write port (idx, rect, valid flag)
//   move_allowed           result, meaningful while result_valid = 1
//   result_valid           result available (DONE state)
//   busy                   high in SCAN and DONE
//   hit_index              blocking check index; 31 = bounds failure
//
// state | meaning
// IDLE  | waiting for test_active; bounds check runs on accept
// SCAN  | one obstacle/peer overlap check per cycle, index chk_idx
// DONE  | result held until test_active drops

module move_collision_responder #(
    parameter int NUM_OBSTACLES    = 8,
    parameter int CHARACTER_WIDTH  = 20,
    parameter int CHARACTER_HEIGHT = 20,
    parameter int XLIMIT           = 319,
    parameter int YLIMIT           = 239
) (
    input  logic       debouncingclock,
    input  logic       reset,
    input  logic       test_active,
    input  logic [9:0] test_x,
    input  logic [9:0] test_y,
    input  logic [9:0] peer0_x,
    input  logic [9:0] peer0_y,
    input  logic [9:0] peer1_x,
    input  logic [9:0] peer1_y,
    input  logic [9:0] peer2_x,
    input  logic [9:0] peer2_y,
    input  logic [2:0] peer_en,
    input  logic       obs_wr_en,
    input  logic [3:0] obs_wr_idx,
    input  logic [9:0] obs_wr_x,
    input  logic [9:0] obs_wr_y,
    input  logic [9:0] obs_wr_w,
    input  logic [9:0] obs_wr_h,
    input  logic       obs_wr_valid,
    output logic       move_allowed,
    output logic       result_valid,
    output logic       busy,
    output logic [4:0] hit_index
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0]  LAST_CHECK = 5'(NUM_OBSTACLES + 2);
    localparam logic [4:0]  BOUNDS_HIT = 5'd31;
    localparam logic [10:0] X_MAX      = 11'(XLIMIT - CHARACTER_WIDTH);
    localparam logic [10:0] Y_MAX      = 11'(YLIMIT - CHARACTER_HEIGHT);
    localparam logic [10:0] CHAR_W     = 11'(CHARACTER_WIDTH);
    localparam logic [10:0] CHAR_H     = 11'(CHARACTER_HEIGHT);

    logic [1:0] state;
    logic [9:0] lat_x;
    logic [9:0] lat_y;
    logic [4:0] chk_idx;

    logic [9:0]               obs_x [NUM_OBSTACLES];
    logic [9:0]               obs_y [NUM_OBSTACLES];
    logic [9:0]               obs_w [NUM_OBSTACLES];
    logic [9:0]               obs_h [NUM_OBSTACLES];
    logic [NUM_OBSTACLES-1:0] obs_valid;

    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [9:0] box_w;
    logic [9:0] box_h;
    logic       box_en;
    logic       box_hit;
    logic       bounds_fail;

    // Obstacle table. Only the valid flags need reset; rectangle contents
    // are ignored while their flag is clear. Out-of-range indices match no
    // slot, so such writes fall through harmlessly.
    always_ff @(posedge debouncingclock) begin
        if (reset) begin
            obs_valid <= '0;
        end else if (obs_wr_en) begin
            for (int i = 0; i < NUM_OBSTACLES; i++) begin
                if (obs_wr_idx == 4'(i)) begin
                    obs_x[i]     <= obs_wr_x;
                    obs_y[i]     <= obs_wr_y;
                    obs_w[i]     <= obs_wr_w;
                    obs_h[i]     <= obs_wr_h;
                    obs_valid[i] <= obs_wr_valid;
                end
            end
        end
    end

    // Box under test for the current scan index: obstacle slots first, then
    // the three peers, whose boxes are the fixed character size.
    always_comb begin
        box_x  = '0;
        box_y  = '0;
        box_w  = '0;
        box_h  = '0;
        box_en = 1'b0;
        for (int i = 0; i < NUM_OBSTACLES; i++) begin
            if (chk_idx == 5'(i)) begin
                box_x  = obs_x[i];
                box_y  = obs_y[i];
                box_w  = obs_w[i];
                box_h  = obs_h[i];
                box_en = obs_valid[i];
            end
        end
        if (chk_idx == 5'(NUM_OBSTACLES)) begin
            box_x  = peer0_x;
            box_y  = peer0_y;
            box_w  = 10'(CHARACTER_WIDTH);
            box_h  = 10'(CHARACTER_HEIGHT);
            box_en = peer_en[0];
        end
        if (chk_idx == 5'(NUM_OBSTACLES + 1)) begin
            box_x  = peer1_x;
            box_y  = peer1_y;
            box_w  = 10'(CHARACTER_WIDTH);
            box_h  = 10'(CHARACTER_HEIGHT);
            box_en = peer_en[1];
        end
        if (chk_idx == 5'(NUM_OBSTACLES + 2)) begin
            box_x  = peer2_x;
            box_y  = peer2_y;
            box_w  = 10'(CHARACTER_WIDTH);
            box_h  = 10'(CHARACTER_HEIGHT);
            box_en = peer_en[2];
        end
    end

    // Strict overlap with 11-bit sums so right/bottom edges never wrap.
    // A degenerate box is excluded explicitly: with w=0 the x-inequalities
    // alone could still pass.
    assign box_hit = box_en && (box_w != 10'd0) && (box_h != 10'd0)
                  && ({1'b0, lat_x} < ({1'b0, box_x} + {1'b0, box_w}))
                  && (({1'b0, lat_x} + CHAR_W) > {1'b0, box_x})
                  && ({1'b0, lat_y} < ({1'b0, box_y} + {1'b0, box_h}))
                  && (({1'b0, lat_y} + CHAR_H) > {1'b0, box_y});

    assign bounds_fail = ({1'b0, test_x} > X_MAX) || ({1'b0, test_y} > Y_MAX);

    always_ff @(posedge debouncingclock) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat_x        <= '0;
            lat_y        <= '0;
            chk_idx      <= '0;
            move_allowed <= 1'b0;
            hit_index    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (test_active) begin
                        lat_x        <= test_x;
                        lat_y        <= test_y;
                        chk_idx      <= '0;
                        move_allowed <= 1'b0;
                        if (bounds_fail) begin
                            state     <= ST_DONE;
                            hit_index <= BOUNDS_HIT;
                        end else begin
                            state     <= ST_SCAN;
                            hit_index <= '0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!test_active) begin
                        state <= ST_IDLE;
                    end else if (box_hit) begin
                        state        <= ST_DONE;
                        move_allowed <= 1'b0;
                        hit_index    <= chk_idx;
                    end else if (chk_idx == LAST_CHECK) begin
                        state        <= ST_DONE;
                        move_allowed <= 1'b1;
                        hit_index    <= '0;
                    end else begin
                        chk_idx <= chk_idx + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (!test_active) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign result_valid = (state == ST_DONE);
    assign busy         = (state == ST_SCAN) || (state == ST_DONE);

endmodule

// File: tb/tb_move_collision_responder.sv
// Directed bench for move_collision_responder with default parameters
// (8 obstacle slots, 20x20 characters, 320x240 screen).
module tb_move_collision_responder;

    logic       debouncingclock = 1'b0;
    logic       reset = 1'b1;
    logic       test_active = 1'b0;
    logic [9:0] test_x = '0;
    logic [9:0] test_y = '0;
    logic [9:0] peer0_x = '0;
    logic [9:0] peer0_y = '0;
    logic [9:0] peer1_x = '0;
    logic [9:0] peer1_y = '0;
    logic [9:0] peer2_x = '0;
    logic [9:0] peer2_y = '0;
    logic [2:0] peer_en = '0;
    logic       obs_wr_en = 1'b0;
    logic [3:0] obs_wr_idx = '0;
    logic [9:0] obs_wr_x = '0;
    logic [9:0] obs_wr_y = '0;
    logic [9:0] obs_wr_w = '0;
    logic [9:0] obs_wr_h = '0;
    logic       obs_wr_valid = 1'b0;
    logic       move_allowed;
    logic       result_valid;
    logic       busy;
    logic [4:0] hit_index;

    int total = 0;
    int bad = 0;
    int lat;

    move_collision_responder dut (
        .debouncingclock(debouncingclock),
        .reset(reset),
        .test_active(test_active),
        .test_x(test_x),
        .test_y(test_y),
        .peer0_x(peer0_x),
        .peer0_y(peer0_y),
        .peer1_x(peer1_x),
        .peer1_y(peer1_y),
        .peer2_x(peer2_x),
        .peer2_y(peer2_y),
        .peer_en(peer_en),
        .obs_wr_en(obs_wr_en),
        .obs_wr_idx(obs_wr_idx),
        .obs_wr_x(obs_wr_x),
        .obs_wr_y(obs_wr_y),
        .obs_wr_w(obs_wr_w),
        .obs_wr_h(obs_wr_h),
        .obs_wr_valid(obs_wr_valid),
        .move_allowed(move_allowed),
        .result_valid(result_valid),
        .busy(busy),
        .hit_index(hit_index)
    );

    always #5 debouncingclock = ~debouncingclock;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] w, input logic [9:0] h, input logic v);
        @(negedge debouncingclock);
        obs_wr_en = 1'b1; obs_wr_idx = idx;
        obs_wr_x = x; obs_wr_y = y; obs_wr_w = w; obs_wr_h = h; obs_wr_valid = v;
        @(negedge debouncingclock);
        obs_wr_en = 1'b0;
    endtask

    // Raises the request and counts rising edges until result_valid is seen
    // (sampled on the falling edge). lat = -1 if the budget runs out.
    // late_x is applied after the first edge, once the position is latched.
    task automatic run_req(input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] late_x, output int n);
        @(negedge debouncingclock);
        test_x = x; test_y = y; test_active = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge debouncingclock);
            if (i == 1) test_x = late_x;
            if (result_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_req();
        @(negedge debouncingclock);
        test_active = 1'b0;
        @(negedge debouncingclock);
    endtask

    initial begin
        repeat (2) @(negedge debouncingclock);
        reset = 1'b0;
        @(negedge debouncingclock);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_allowed", move_allowed, 0);
        chk("rst_hit", hit_index, 0);

        // Empty table, no peers: full scan of 11 checks.
        run_req(100, 100, 100, lat);
        chk("empty_lat", lat, 12);
        chk("empty_allowed", move_allowed, 1);
        chk("empty_hit", hit_index, 0);
        chk("empty_busy", busy, 1);
        release_req();
        chk("empty_release", result_valid, 0);
        chk("empty_idle_busy", busy, 0);

        // Slot 2 blocks.
        wr(2, 110, 100, 20, 20, 1);
        run_req(100, 100, 100, lat);
        chk("slot2_lat", lat, 4);
        chk("slot2_allowed", move_allowed, 0);
        chk("slot2_hit", hit_index, 2);
        repeat (3) @(negedge debouncingclock);
        chk("slot2_hold_hit", hit_index, 2);
        chk("slot2_hold_valid", result_valid, 1);
        release_req();
        wr(2, 110, 100, 20, 20, 0);

        // Edge touching is allowed, one pixel in is blocked.
        wr(0, 120, 100, 20, 20, 1);
        run_req(100, 100, 100, lat);
        chk("touch_lat", lat, 12);
        chk("touch_allowed", move_allowed, 1);
        release_req();
        run_req(101, 100, 101, lat);
        chk("over_lat", lat, 2);
        chk("over_allowed", move_allowed, 0);
        chk("over_hit", hit_index, 0);
        release_req();

        // Bounds: beyond right edge, beyond bottom, and the last legal corner.
        run_req(300, 50, 300, lat);
        chk("bx_lat_ok", (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        chk("bx_allowed", move_allowed, 0);
        chk("bx_hit", hit_index, 31);
        release_req();
        run_req(0, 220, 0, lat);
        chk("by_hit", hit_index, 31);
        chk("by_allowed", move_allowed, 0);
        release_req();
        run_req(299, 219, 299, lat);
        chk("corner_lat", lat, 12);
        chk("corner_allowed", move_allowed, 1);
        release_req();
        wr(0, 120, 100, 20, 20, 0);

        // Peer 1 overlaps by one row; enabled then disabled.
        peer0_x = 100; peer0_y = 100;
        peer1_x = 100; peer1_y = 119;
        peer2_x = 100; peer2_y = 100;
        peer_en = 3'b010;
        run_req(100, 100, 100, lat);
        chk("peer_lat", lat, 11);
        chk("peer_allowed", move_allowed, 0);
        chk("peer_hit", hit_index, 9);
        release_req();
        peer_en = 3'b000;
        run_req(100, 100, 100, lat);
        chk("peer_off_allowed", move_allowed, 1);
        release_req();
        peer_en = 3'b100;
        run_req(100, 100, 100, lat);
        chk("peer2_hit", hit_index, 10);
        chk("peer2_lat", lat, 12);
        release_req();
        peer_en = 3'b000;

        // Zero-width box never overlaps.
        wr(3, 110, 100, 0, 20, 1);
        run_req(100, 100, 100, lat);
        chk("zero_w_allowed", move_allowed, 1);
        release_req();
        wr(3, 110, 100, 0, 20, 0);

        // Write to a nonexistent slot is ignored.
        wr(8, 100, 100, 20, 20, 1);
        run_req(100, 100, 100, lat);
        chk("oob_wr_allowed", move_allowed, 1);
        release_req();

        // Position latched: moving test_x onto slot 6 after accept has no effect.
        wr(6, 200, 100, 20, 20, 1);
        run_req(100, 100, 200, lat);
        chk("latch_allowed", move_allowed, 1);
        release_req();
        run_req(200, 100, 200, lat);
        chk("slot6_hit", hit_index, 6);
        release_req();
        wr(6, 200, 100, 20, 20, 0);

        // Abort mid-scan.
        wr(5, 100, 100, 20, 20, 1);
        @(negedge debouncingclock);
        test_x = 100; test_y = 100; test_active = 1'b1;
        repeat (3) @(negedge debouncingclock);
        chk("abort_busy_scan", busy, 1);
        test_active = 1'b0;
        @(negedge debouncingclock);
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);

        // Reset during scan, with a concurrent write that must be dropped.
        test_active = 1'b1;
        repeat (5) @(negedge debouncingclock);
        reset = 1'b1;
        obs_wr_en = 1'b1; obs_wr_idx = 1; obs_wr_x = 100; obs_wr_y = 100;
        obs_wr_w = 20; obs_wr_h = 20; obs_wr_valid = 1'b1;
        @(negedge debouncingclock);
        reset = 1'b0; obs_wr_en = 1'b0; test_active = 1'b0;
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_allowed", move_allowed, 0);
        chk("mid_rst_hit", hit_index, 0);
        run_req(100, 100, 100, lat);
        chk("post_rst_lat", lat, 12);
        chk("post_rst_allowed", move_allowed, 1);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
